// File: rtl/iir_biquad_seq_if.sv
// Control bundle between the biquad sequencer and the shared multiply-add datapath.
// Ports (master = sequencer side):
//   start, clr                   : sample strobe and synchronous abort/state clear into the sequencer
//   controlS, controlC, controlZ : coefficient, sample and addend mux selects
//   en_acum1, en_fk, en_acum2,
//   en_acum3, en_yk, en_shift    : datapath register load enables
//   clr_state                    : zero all filter state registers
//   busy, done, overrun          : status (busy, yk valid pulse, sticky overrun)
interface iir_biquad_seq_if;
    localparam int unsigned SW  = 3;
    localparam int unsigned CSW = 2;
    localparam int unsigned ZW  = 3;

    logic           start;
    logic           clr;
    logic [SW-1:0]  controlS;
    logic [CSW-1:0] controlC;
    logic [ZW-1:0]  controlZ;
    logic           en_acum1;
    logic           en_fk;
    logic           en_acum2;
    logic           en_acum3;
    logic           en_yk;
    logic           en_shift;
    logic           clr_state;
    logic           busy;
    logic           done;
    logic           overrun;

    modport master (
        input  start, clr,
        output controlS, controlC, controlZ,
        output en_acum1, en_fk, en_acum2, en_acum3, en_yk, en_shift,
        output clr_state, busy, done, overrun
    );

    modport slave (
        output start, clr,
        input  controlS, controlC, controlZ,
        input  en_acum1, en_fk, en_acum2, en_acum3, en_yk, en_shift,
        input  clr_state, busy, done, overrun
    );
endinterface

// File: rtl/iir_biquad_seq.sv
// Sequencer for a shared-multiplier second-order IIR section.
// Walks five multiply-add steps (result = coefS*selC + selZ) per sample strobe:
//   fk = Uk + a1*fk1 + a2*fk2 ;  yk = b0*fk + b1*fk1 + b2*fk2
// then shifts the delay line and pulses done.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : iir_biquad_seq_if.master (start/clr in; selects, enables, status out)
// All outputs are registered; they are decoded from the next state so they line up
// with the state they describe.
module iir_biquad_seq #(
    parameter int unsigned STEP_CYC = 1,
    parameter int unsigned CW       = 4
) (
    input  logic             clk,
    input  logic             reset,
    iir_biquad_seq_if.master bus
);
    localparam int unsigned SW  = 3;
    localparam int unsigned CSW = 2;
    localparam int unsigned ZW  = 3;
    localparam int unsigned EW  = 6;

    localparam int unsigned EN_ACUM1 = 0;
    localparam int unsigned EN_FK    = 1;
    localparam int unsigned EN_ACUM2 = 2;
    localparam int unsigned EN_ACUM3 = 3;
    localparam int unsigned EN_YK    = 4;
    localparam int unsigned EN_SHIFT = 5;

    localparam logic [CW-1:0] LAST_CNT = CW'(STEP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        STEP3 = 3'd3,
        STEP4 = 3'd4,
        STEP5 = 3'd5,
        SHIFT = 3'd6,
        DONE  = 3'd7
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           step_last;
    logic           last_d;

    logic [SW-1:0]  sel_s_q, sel_s_d;
    logic [CSW-1:0] sel_c_q, sel_c_d;
    logic [ZW-1:0]  sel_z_q, sel_z_d;
    logic [EW-1:0]  en_q, en_d;
    logic           clr_state_q, clr_state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           overrun_q, overrun_d;

    // State, step-wait counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_s_q     <= '0;
            sel_c_q     <= '0;
            sel_z_q     <= '0;
            en_q        <= '0;
            clr_state_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_s_q     <= sel_s_d;
            sel_c_q     <= sel_c_d;
            sel_z_q     <= sel_z_d;
            en_q        <= en_d;
            clr_state_q <= clr_state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next state; clr overrides everything, start only matters in IDLE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_last = (cnt_q == LAST_CNT);
        if (bus.clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = STEP1;
                        cnt_d   = '0;
                    end
                end
                STEP1, STEP2, STEP3, STEP4, STEP5: begin
                    if (step_last) begin
                        state_d = (state_q == STEP5) ? SHIFT : state_e'(state_q + 3'd1);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SHIFT:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state; a step's enable fires in its last cycle only
    always_comb begin
        sel_s_d     = '0;
        sel_c_d     = '0;
        sel_z_d     = '0;
        en_d        = '0;
        last_d      = (cnt_d == LAST_CNT);
        clr_state_d = bus.clr;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        // A start that lands while busy (including DONE) is lost and flagged until clr
        overrun_d   = bus.clr ? 1'b0 : (overrun_q | (bus.start & (state_q != IDLE)));
        case (state_d)
            STEP1: begin
                sel_s_d = 3'b001; sel_c_d = 2'b01; sel_z_d = 3'b001;
                en_d[EN_ACUM1] = last_d;
            end
            STEP2: begin
                sel_s_d = 3'b010; sel_c_d = 2'b10; sel_z_d = 3'b011;
                en_d[EN_FK] = last_d;
            end
            STEP3: begin
                sel_s_d = 3'b011; sel_c_d = 2'b11; sel_z_d = 3'b000;
                en_d[EN_ACUM2] = last_d;
            end
            STEP4: begin
                sel_s_d = 3'b100; sel_c_d = 2'b01; sel_z_d = 3'b100;
                en_d[EN_ACUM3] = last_d;
            end
            STEP5: begin
                sel_s_d = 3'b101; sel_c_d = 2'b10; sel_z_d = 3'b101;
                en_d[EN_YK] = last_d;
            end
            SHIFT:   en_d[EN_SHIFT] = 1'b1;
            default: ;
        endcase
    end

    assign bus.controlS  = sel_s_q;
    assign bus.controlC  = sel_c_q;
    assign bus.controlZ  = sel_z_q;
    assign bus.en_acum1  = en_q[EN_ACUM1];
    assign bus.en_fk     = en_q[EN_FK];
    assign bus.en_acum2  = en_q[EN_ACUM2];
    assign bus.en_acum3  = en_q[EN_ACUM3];
    assign bus.en_yk     = en_q[EN_YK];
    assign bus.en_shift  = en_q[EN_SHIFT];
    assign bus.clr_state = clr_state_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_iir_biquad_seq.sv
// Bench for iir_biquad_seq: two sequencers (STEP_CYC=1 and 3) share one stimulus stream.
// Each drives its own fixed-point datapath model; outputs are checked every cycle against a
// per-sample timeline, and each done is checked against a sample-level biquad reference.
module tb_iir_biquad_seq;
    localparam int NONE = -1000000;
    localparam int A1 = 19661;
    localparam int A2 = -8192;
    localparam int B0 = 4096;
    localparam int B1 = 8192;
    localparam int B2 = 4096;
    localparam int ONE = 16384;

    logic clk = 1'b0;
    logic reset;
    logic start_s;
    logic clr_s;
    int   uk_s;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iir_biquad_seq_if if_a ();
    iir_biquad_seq_if if_b ();
    assign if_a.start = start_s;
    assign if_a.clr   = clr_s;
    assign if_b.start = start_s;
    assign if_b.clr   = clr_s;

    iir_biquad_seq #(.STEP_CYC(1), .CW(4)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
    iir_biquad_seq #(.STEP_CYC(3), .CW(4)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b));

    // {S[17:15], C[14:13], Z[12:10], acum1, fk, acum2, acum3, yk, shift, clr_state, busy, done, overrun}
    logic [17:0] out_v [2];
    assign out_v[0] = {if_a.controlS, if_a.controlC, if_a.controlZ, if_a.en_acum1, if_a.en_fk,
                       if_a.en_acum2, if_a.en_acum3, if_a.en_yk, if_a.en_shift, if_a.clr_state,
                       if_a.busy, if_a.done, if_a.overrun};
    assign out_v[1] = {if_b.controlS, if_b.controlC, if_b.controlZ, if_b.en_acum1, if_b.en_fk,
                       if_b.en_acum2, if_b.en_acum3, if_b.en_yk, if_b.en_shift, if_b.clr_state,
                       if_b.busy, if_b.done, if_b.overrun};

    function automatic int mulq(int c, int x);
        longint p;
        p = longint'(c) * longint'(x);
        return int'(p >>> 14);
    endfunction

    // Fixed-point datapath driven by each sequencer's controls
    int yk_v [2];
    for (genvar g = 0; g < 2; g++) begin : g_dp
        int uk, fk, fk1, fk2, ac1, ac2, ac3, yk;
        int cs, cc, cz, mac;
        always_comb begin
            case (out_v[g][17:15])
                3'd1: cs = A1;
                3'd2: cs = A2;
                3'd3: cs = B0;
                3'd4: cs = B1;
                3'd5: cs = B2;
                default: cs = 0;
            endcase
            case (out_v[g][14:13])
                2'd1: cc = fk1;
                2'd2: cc = fk2;
                2'd3: cc = fk;
                default: cc = 0;
            endcase
            case (out_v[g][12:10])
                3'd1: cz = uk;
                3'd2: cz = yk;
                3'd3: cz = ac1;
                3'd4: cz = ac2;
                3'd5: cz = ac3;
                default: cz = 0;
            endcase
            mac = mulq(cs, cc) + cz;
        end
        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                uk <= 0; fk <= 0; fk1 <= 0; fk2 <= 0;
                ac1 <= 0; ac2 <= 0; ac3 <= 0; yk <= 0;
            end else begin
                if (start_s && !out_v[g][2] && !clr_s) uk <= uk_s;
                if (out_v[g][3]) begin
                    fk <= 0; fk1 <= 0; fk2 <= 0;
                    ac1 <= 0; ac2 <= 0; ac3 <= 0; yk <= 0;
                end else begin
                    if (out_v[g][9]) ac1 <= mac;
                    if (out_v[g][8]) fk  <= mac;
                    if (out_v[g][7]) ac2 <= mac;
                    if (out_v[g][6]) ac3 <= mac;
                    if (out_v[g][5]) yk  <= mac;
                    if (out_v[g][4]) begin
                        fk2 <= fk1;
                        fk1 <= fk;
                    end
                end
            end
        end
        assign yk_v[g] = yk;
    end

    // Reference: sample timeline per instance plus a biquad evaluated per accepted sample
    typedef struct {
        int inst;
        int y;
        int cyc;
    } exp_t;
    exp_t sbq [$];

    int seq_s [2];
    int clrst [2];
    bit ovr [2];
    int rf1 [2];
    int rf2 [2];

    function automatic int sc_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit active(int i, int n);
        return (seq_s[i] != NONE) && (n >= seq_s[i]) && (n <= seq_s[i] + 5 * sc_of(i) + 1);
    endfunction

    function automatic logic [17:0] expv(int i, int n);
        logic [17:0] e;
        int sc, k, st;
        e  = '0;
        sc = sc_of(i);
        if (active(i, n)) begin
            k    = n - seq_s[i];
            e[2] = 1'b1;
            if (k < 5 * sc) begin
                st = k / sc;
                e[17:15] = 3'(st + 1);
                case (st)
                    0: begin e[14:13] = 2'd1; e[12:10] = 3'd1; end
                    1: begin e[14:13] = 2'd2; e[12:10] = 3'd3; end
                    2: begin e[14:13] = 2'd3; e[12:10] = 3'd0; end
                    3: begin e[14:13] = 2'd1; e[12:10] = 3'd4; end
                    default: begin e[14:13] = 2'd2; e[12:10] = 3'd5; end
                endcase
                if (k % sc == sc - 1) e[9 - st] = 1'b1;
            end else if (k == 5 * sc) begin
                e[4] = 1'b1;
            end else begin
                e[1] = 1'b1;
            end
        end
        if (clrst[i] == n) e[3] = 1'b1;
        e[0] = ovr[i];
        return e;
    endfunction

    task automatic purge(int i, int after);
        for (int k = sbq.size() - 1; k >= 0; k--)
            if (sbq[k].inst == i && sbq[k].cyc > after) sbq.delete(k);
    endtask

    task automatic model_clear(int i);
        seq_s[i] = NONE;
        clrst[i] = NONE;
        ovr[i]   = 1'b0;
        rf1[i]   = 0;
        rf2[i]   = 0;
        purge(i, NONE);
    endtask

    task automatic model_step(int i, int n);
        int f, y;
        if (clr_s) begin
            seq_s[i] = NONE;
            clrst[i] = n + 1;
            ovr[i]   = 1'b0;
            rf1[i]   = 0;
            rf2[i]   = 0;
            purge(i, n);
        end else if (start_s) begin
            if (active(i, n)) begin
                ovr[i] = 1'b1;
            end else begin
                f = uk_s + mulq(A1, rf1[i]) + mulq(A2, rf2[i]);
                y = mulq(B0, f) + mulq(B1, rf1[i]) + mulq(B2, rf2[i]);
                rf2[i]   = rf1[i];
                rf1[i]   = f;
                seq_s[i] = n + 1;
                sbq.push_back('{i, y, n + 5 * sc_of(i) + 2});
            end
        end
    endtask

    task automatic check_done(int i, int n);
        int idx;
        idx = -1;
        for (int k = 0; k < sbq.size(); k++)
            if (idx < 0 && sbq[k].inst == i) idx = k;
        vectors++;
        if (idx < 0) begin
            miscompares++;
            $display("FAIL done_unexpected inst%0d cyc%0d: got done=1 want no pending sample", i, n);
        end else begin
            vectors++;
            if (sbq[idx].cyc != n) begin
                miscompares++;
                $display("FAIL done_cycle inst%0d: got cyc %0d want cyc %0d", i, n, sbq[idx].cyc);
            end
            vectors++;
            if (yk_v[i] != sbq[idx].y) begin
                miscompares++;
                $display("FAIL yk inst%0d cyc%0d: got %0d want %0d", i, n, yk_v[i], sbq[idx].y);
            end
            sbq.delete(idx);
        end
    endtask

    // Monitor: compare this cycle, then advance the reference with what the DUT will sample
    always @(negedge clk) begin
        logic [17:0] e;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                model_clear(i);
                e = '0;
            end else begin
                e = expv(i, cyc);
            end
            vectors++;
            if (out_v[i] !== e) begin
                miscompares++;
                $display("FAIL ctl inst%0d cyc%0d: got %b want %b", i, cyc, out_v[i], e);
            end
            if (reset && out_v[i][1]) check_done(i, cyc);
            if (reset) model_step(i, cyc);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(bit s, bit c, int u);
        start_s = s;
        clr_s   = c;
        uk_s    = u;
        tick(1);
        start_s = 1'b0;
        clr_s   = 1'b0;
    endtask

    function automatic int rnd_uk();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        int gap, kind;
        reset   = 1'b0;
        start_s = 1'b0;
        clr_s   = 1'b0;
        uk_s    = 0;
        tick(3);
        reset = 1'b1;
        tick(9);

        // Impulse response over 8 samples at the minimum overrun-free spacing of the slow unit
        pulse(1'b1, 1'b0, ONE);
        tick(17);
        for (int s = 0; s < 7; s++) begin
            pulse(1'b1, 1'b0, 0);
            tick(17);
        end

        // Second start lands in STEP3 of the fast unit
        pulse(1'b1, 1'b0, rnd_uk());
        tick(2);
        pulse(1'b1, 1'b0, rnd_uk());
        tick(20);
        pulse(1'b0, 1'b1, 0);
        tick(3);

        // clr in the first cycle of STEP4 of the slow unit, then a clean run
        pulse(1'b1, 1'b0, rnd_uk());
        tick(9);
        pulse(1'b0, 1'b1, 0);
        tick(2);
        pulse(1'b1, 1'b0, rnd_uk());
        tick(18);

        // clr and start together while idle
        pulse(1'b1, 1'b1, rnd_uk());
        tick(3);

        // Async reset between edges during STEP2 of the fast unit
        pulse(1'b1, 1'b0, rnd_uk());
        tick(1);
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (out_v[i] !== 18'd0) begin
                miscompares++;
                $display("FAIL async_reset inst%0d: got %b want all zero", i, out_v[i]);
            end
        end
        tick(2);
        reset = 1'b1;
        tick(3);
        pulse(1'b1, 1'b0, ONE);
        tick(18);

        // Randomized starts, aborts and collisions
        for (int r = 0; r < 60; r++) begin
            gap = int'($urandom_range(0, 22));
            if (gap > 0) tick(gap);
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      pulse(1'b0, 1'b1, 0);
            else if (kind == 1) pulse(1'b1, 1'b1, rnd_uk());
            else                pulse(1'b1, 1'b0, rnd_uk());
        end
        tick(25);

        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending samples want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
